// File: rtl/nios2_oci_trace_capture.sv
// nios2_oci_trace_capture
//   Captures Nios II OCI debug-control-trace (DCT) words into a
//   first-word-fall-through FIFO. Keeps saturating statistics and runs an
//   end-of-test drain sequence that ends in a sticky test_has_ended flag.
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   dct_buffer     trace word
//   dct_count      number of valid trace slots in dct_buffer (0 = ignore word)
//   dct_valid      push strobe, one word per cycle
//   test_ending    level, requests the end-of-test drain
//   rd_data        {dct_count, dct_buffer} of the FIFO head
//   rd_valid       FIFO not empty
//   rd_ready       consumer accepts the head
//   fill_level     registered occupancy, 0..DEPTH
//   drop_count     words lost to overflow, saturating
//   slot_total     sum of dct_count over accepted words, saturating
//   rd_timestamp   cycle counter at acceptance of the head word
//                  (only when NIOS2_OCI_TRACE_TIMESTAMP_EN is defined)
//   test_has_ended drain complete, sticky until reset
//
// Optional feature macro: NIOS2_OCI_TRACE_TIMESTAMP_EN

module nios2_oci_trace_capture #(
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUF_W-1:0]        dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_valid,
  input  logic                    test_ending,
  output logic [BUF_W+CNT_W-1:0]  rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_W:0]         fill_level,
  output logic [STAT_W-1:0]       drop_count,
  output logic [STAT_W-1:0]       slot_total,
`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  output logic [31:0]             rd_timestamp,
`endif
  output logic                    test_has_ended
);

  localparam int DATA_W = BUF_W + CNT_W;
`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  localparam int WORD_W = DATA_W + 32;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]     fill_level_reg;
  logic [STAT_W-1:0]   drop_count_reg, slot_total_reg;
  logic                test_has_ended_reg;
  logic [STAT_W:0]     slot_sum;
  logic [WORD_W-1:0]   wr_word;
  logic                push_req, pop, accept, drop, full;

`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  logic [31:0]         ts_reg;

  always_ff @(posedge clk) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + 32'd1;
  end

  assign wr_word      = {ts_reg, dct_count, dct_buffer};
  assign rd_timestamp = mem[rd_ptr_reg][WORD_W-1 -: 32];
`else
  assign wr_word      = {dct_count, dct_buffer};
`endif

  // Head is read asynchronously so a word accepted at one edge is visible
  // right after it (first-word fall-through).
  assign rd_data  = mem[rd_ptr_reg][DATA_W-1:0];
  assign rd_valid = (fill_level_reg != '0);

  always_comb begin
    push_req = dct_valid && (state_reg == RUN) && (dct_count != '0);
    pop      = rd_valid && rd_ready;
    full     = (fill_level_reg == FULL_LEVEL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept   = push_req && (!full || pop);
    drop     = push_req && !accept;
    slot_sum = {1'b0, slot_total_reg} + (STAT_W+1)'(dct_count);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (test_ending) state_next = DRAIN;
      DRAIN:   if (fill_level_reg == '0 && !push_req) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = RUN;
    endcase
  end

  // Storage has no reset; validity is tracked by fill_level alone.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= RUN;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      fill_level_reg     <= '0;
      drop_count_reg     <= '0;
      slot_total_reg     <= '0;
      test_has_ended_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      test_has_ended_reg <= (state_next == ENDED);
      if (accept) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      case ({accept, pop})
        2'b10:   fill_level_reg <= fill_level_reg + (ADDR_W+1)'(1);
        2'b01:   fill_level_reg <= fill_level_reg - (ADDR_W+1)'(1);
        default: fill_level_reg <= fill_level_reg;
      endcase
      if (drop && drop_count_reg != '1)
        drop_count_reg <= drop_count_reg + STAT_W'(1);
      if (accept)
        slot_total_reg <= slot_sum[STAT_W] ? '1 : slot_sum[STAT_W-1:0];
    end
  end

  assign fill_level     = fill_level_reg;
  assign drop_count     = drop_count_reg;
  assign slot_total     = slot_total_reg;
  assign test_has_ended = test_has_ended_reg;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Testbench for nios2_oci_trace_capture: directed stimulus with a scoreboard
// queue of expected FIFO words, checked by an independent pop monitor.
module tb_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        dct_valid = 1'b0;
  logic        test_ending = 1'b0;
  logic [33:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic [15:0] slot_total;
  logic        test_has_ended;
`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  logic [31:0] rd_timestamp;
`endif

  logic [33:0] exp_q[$];
  logic [33:0] exp_word;
  int          checks = 0;
  int          errors = 0;

  nios2_oci_trace_capture dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .fill_level     (fill_level),
    .drop_count     (drop_count),
    .slot_total     (slot_total),
`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
    .rd_timestamp   (rd_timestamp),
`endif
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  // Pop monitor: every accepted head word must match the scoreboard front.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected actual=%h required=none", rd_data);
        end else begin
          exp_word = exp_q.pop_front();
          $display("pop data=%h", rd_data);
          if (rd_data !== exp_word) begin
            errors++;
            $display("FAIL pop_data actual=%h required=%h", rd_data, exp_word);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [29:0] d, input logic [3:0] c,
                       input logic rdy, input logic te, input bit exp_acc);
    dct_valid   = v;
    dct_buffer  = d;
    dct_count   = c;
    rd_ready    = rdy;
    test_ending = te;
    if (exp_acc) exp_q.push_back({c, d});
    tick();
    dct_valid   = 1'b0;
    test_ending = 1'b0;
  endtask

  task automatic pop_all();
    dct_valid = 1'b0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 64 && rd_valid; i++) tick();
    chk("drain_rd_valid", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    dct_valid   = 1'b0;
    rd_ready    = 1'b0;
    test_ending = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_slot", 64'(slot_total), 64'd0);
    chk("rst_ended", 64'(test_has_ended), 64'd0);

    // Three words, counts 5,15,1, no reads.
    drive(1'b1, 30'h0111_1111, 4'd5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 30'h0222_2222, 4'd15, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 30'h0333_3333, 4'd1, 1'b0, 1'b0, 1'b1);
    chk("t1_fill", 64'(fill_level), 64'd3);
    chk("t1_slot", 64'(slot_total), 64'd21);
    chk("t1_drop", 64'(drop_count), 64'd0);
    chk("t1_head", 64'(rd_data), 64'({4'd5, 30'h0111_1111}));
    pop_all();

    // Overflow: 20 words into 16 slots; counts 1..15,1 accepted (sum 121).
    for (int i = 0; i < 20; i++)
      drive(1'b1, 30'(32'h200 + i), 4'((i % 15) + 1), 1'b0, 1'b0, i < 16);
    chk("t2_fill", 64'(fill_level), 64'd16);
    chk("t2_drop", 64'(drop_count), 64'd4);
    chk("t2_slot", 64'(slot_total), 64'd142);
    pop_all();

    // Full with simultaneous push and pop for 5 cycles.
    for (int i = 0; i < 16; i++)
      drive(1'b1, 30'(32'h300 + i), 4'd2, 1'b0, 1'b0, 1'b1);
    chk("t3_full", 64'(fill_level), 64'd16);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 30'(32'h400 + i), 4'd3, 1'b1, 1'b0, 1'b1);
    chk("t3_fill", 64'(fill_level), 64'd16);
    chk("t3_drop", 64'(drop_count), 64'd4);
    chk("t3_slot", 64'(slot_total), 64'd189);
    pop_all();

    // End-of-test drain: 8 words plus one pushed alongside test_ending.
    for (int i = 0; i < 8; i++)
      drive(1'b1, 30'(32'h500 + i), 4'd1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 30'h508, 4'd1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 30'h509, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 30'h50A, 4'd7, 1'b0, 1'b0, 1'b0);
    chk("t4_fill", 64'(fill_level), 64'd9);
    chk("t4_drop", 64'(drop_count), 64'd4);
    chk("t4_slot", 64'(slot_total), 64'd198);
    chk("t4_ended_early", 64'(test_has_ended), 64'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 64 && fill_level != 5'd0; i++) tick();
    chk("t4_drained", 64'(fill_level), 64'd0);
    chk("t4_ended_at_zero", 64'(test_has_ended), 64'd0);
    tick();
    chk("t4_ended", 64'(test_has_ended), 64'd1);
    drive(1'b1, 30'h50B, 4'd3, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 30'h50C, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("t4_ended_sticky", 64'(test_has_ended), 64'd1);
    chk("t4_ignored", 64'(fill_level), 64'd0);
    chk("t4_slot_hold", 64'(slot_total), 64'd198);

    // Reset in the middle of a drain with 6 words held.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive(1'b1, 30'(32'h600 + i), 4'd2, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 30'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t5_fill_drain", 64'(fill_level), 64'd6);
    do_reset();
    chk("t5_fill", 64'(fill_level), 64'd0);
    chk("t5_rd_valid", 64'(rd_valid), 64'd0);
    chk("t5_drop", 64'(drop_count), 64'd0);
    chk("t5_slot", 64'(slot_total), 64'd0);
    chk("t5_ended", 64'(test_has_ended), 64'd0);
    drive(1'b1, 30'h777, 4'd4, 1'b0, 1'b0, 1'b1);
    chk("t5_run_push", 64'(fill_level), 64'd1);
    chk("t5_run_slot", 64'(slot_total), 64'd4);
    pop_all();

    // dct_count==0 is ignored entirely.
    drive(1'b1, 30'h123, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_zero_fill", 64'(fill_level), 64'd0);
    chk("t6_zero_slot", 64'(slot_total), 64'd4);

    // slot_total saturation: 4368*15 = 65520, then two more words.
    do_reset();
    for (int i = 0; i < 4368; i++)
      drive(1'b1, 30'(i), 4'd15, 1'b1, 1'b0, 1'b1);
    chk("t7_slot_pre", 64'(slot_total), 64'd65520);
    drive(1'b1, 30'h3FFF_0001, 4'd15, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 30'h3FFF_0002, 4'd15, 1'b1, 1'b0, 1'b1);
    chk("t7_slot_sat", 64'(slot_total), 64'd65535);
    pop_all();

`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
    // Cycle counter is 0 right after the reset edge.
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    drive(1'b1, 30'h0A0A, 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b1, 30'h0D0D, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("ts_first", 64'(rd_timestamp), 64'd10);
    drive(1'b0, 30'h0, 4'd0, 1'b1, 1'b0, 1'b0);
    rd_ready = 1'b0;
    chk("ts_second", 64'(rd_timestamp), 64'd13);
    pop_all();
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
